huffman_decode: RTL and testbench

//  Serial Huffman decoder, inverse of the Huffman_code encoder. Latches the encoder's 10-entry

---
 rtl/huffman_decode.sv | 141 ++++++++++++++
 tb/tb_huffman_decode.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decode.sv
// Serial Huffman decoder: latches a 10-entry codebook, shifts in an MSB-first bitstream
// one bit per handshake and emits the lowest-index codebook entry that matches.
module huffman_decode #(
    parameter int NSYM   = 10,
    parameter int CW     = 13,
    parameter int MAXLEN = 9
) (
    input  logic          Clk_in,
    input  logic          Rst,
    input  logic          Start_decode,
    input  logic [CW-1:0] Code0,
    input  logic [CW-1:0] Code1,
    input  logic [CW-1:0] Code2,
    input  logic [CW-1:0] Code3,
    input  logic [CW-1:0] Code4,
    input  logic [CW-1:0] Code5,
    input  logic [CW-1:0] Code6,
    input  logic [CW-1:0] Code7,
    input  logic [CW-1:0] Code8,
    input  logic [CW-1:0] Code9,
    input  logic          Bit_in,
    input  logic          Bit_valid,
    output logic          Bit_ready,
    output logic [3:0]    Sym_out,
    output logic          Sym_valid,
    input  logic          Sym_ready,
    output logic          Err,
    output logic          Busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    localparam logic [3:0] MAX_LEN4 = 4'(MAXLEN);

    logic [1:0]        state_reg;
    logic [MAXLEN-1:0] acc_reg;
    logic [MAXLEN-1:0] acc_next;
    logic [3:0]        cnt_reg;
    logic [3:0]        cnt_next;
    logic [3:0]        sym_out_reg;
    logic [CW-1:0]     code_in [NSYM];
    logic [NSYM-1:0]   match;
    logic [3:0]        sym_idx;
    logic              hit;

    assign code_in[0] = Code0;
    assign code_in[1] = Code1;
    assign code_in[2] = Code2;
    assign code_in[3] = Code3;
    assign code_in[4] = Code4;
    assign code_in[5] = Code5;
    assign code_in[6] = Code6;
    assign code_in[7] = Code7;
    assign code_in[8] = Code8;
    assign code_in[9] = Code9;

    // Matching looks at the accumulator as it will be after the incoming bit.
    assign acc_next = {acc_reg[MAXLEN-2:0], Bit_in};
    assign cnt_next = cnt_reg + 4'd1;

    genvar gi;
    generate
        for (gi = 0; gi < NSYM; gi++) begin : g_entry
            logic [CW-1:0]     entry_reg;
            logic [3:0]        len;
            logic [MAXLEN-1:0] mask;

            always_ff @(posedge Clk_in) begin
                if (Rst) begin
                    entry_reg <= '0;
                end else if (Start_decode) begin
                    entry_reg <= code_in[gi];
                end
            end

            assign len  = entry_reg[CW-1:CW-4];
            // Code bits above the entry length are don't-care.
            assign mask = ~({MAXLEN{1'b1}} << len);
            assign match[gi] = (len != 4'd0) && (len <= MAX_LEN4) && (len == cnt_next) &&
                               (((acc_next ^ entry_reg[MAXLEN-1:0]) & mask) == '0);
        end
    endgenerate

    always_comb begin
        sym_idx = 4'd0;
        hit     = |match;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (match[i]) begin
                sym_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge Clk_in) begin
        if (Rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            sym_out_reg <= '0;
        end else if (Start_decode) begin
            state_reg <= SHIFT;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                SHIFT: begin
                    if (Bit_valid) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_next;
                        if (hit) begin
                            sym_out_reg <= sym_idx;
                            state_reg   <= EMIT;
                        end else if (cnt_next == MAX_LEN4) begin
                            state_reg <= ERROR;
                        end
                    end
                end
                EMIT: begin
                    if (Sym_ready) begin
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end
                end
                default: begin
                    state_reg <= state_reg;
                end
            endcase
        end
    end

    assign Bit_ready = (state_reg == SHIFT);
    assign Sym_valid = (state_reg == EMIT);
    assign Err       = (state_reg == ERROR);
    assign Busy      = (state_reg == SHIFT) || (state_reg == EMIT);
    assign Sym_out   = sym_out_reg;

endmodule

// File: tb/tb_huffman_decode.sv
// Self-checking bench for huffman_decode: codeword table plus scoreboard queue,
// with hand-written sequences for backpressure, error, reset and restart cases.
module tb_huffman_decode;

    logic        Clk_in = 1'b0;
    logic        Rst;
    logic        Start_decode;
    logic [12:0] code_in [10];
    logic        Bit_in;
    logic        Bit_valid;
    logic        Bit_ready;
    logic [3:0]  Sym_out;
    logic        Sym_valid;
    logic        Sym_ready;
    logic        Err;
    logic        Busy;

    always #5 Clk_in = ~Clk_in;

    huffman_decode dut (
        .Clk_in      (Clk_in),
        .Rst         (Rst),
        .Start_decode(Start_decode),
        .Code0       (code_in[0]),
        .Code1       (code_in[1]),
        .Code2       (code_in[2]),
        .Code3       (code_in[3]),
        .Code4       (code_in[4]),
        .Code5       (code_in[5]),
        .Code6       (code_in[6]),
        .Code7       (code_in[7]),
        .Code8       (code_in[8]),
        .Code9       (code_in[9]),
        .Bit_in      (Bit_in),
        .Bit_valid   (Bit_valid),
        .Bit_ready   (Bit_ready),
        .Sym_out     (Sym_out),
        .Sym_valid   (Sym_valid),
        .Sym_ready   (Sym_ready),
        .Err         (Err),
        .Busy        (Busy)
    );

    typedef struct {
        int         book;
        logic [8:0] bits;
        int         nbits;
        logic [3:0] sym;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q [$];
    logic [12:0] books [4][10];
    vec_t        vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted symbol is compared against the oldest expectation.
    always @(negedge Clk_in) begin
        if (Sym_valid === 1'b1 && Sym_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sym: got %0d expected none", Sym_out);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                $display("sym out=%0d exp=%0d", Sym_out, e);
                chk("sym", 32'(Sym_out), 32'(e));
            end
        end
    end

    task automatic load_book(input int b);
        for (int j = 0; j < 10; j++) code_in[j] = books[b][j];
        Start_decode = 1'b1;
        @(posedge Clk_in); #1;
        Start_decode = 1'b0;
        // Codebook must stay latched even while the inputs wander.
        for (int j = 0; j < 10; j++) code_in[j] = 13'($urandom);
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        Bit_valid = 1'b1;
        Bit_in    = b;
        while (Bit_ready !== 1'b1 && n < 50) begin
            @(posedge Clk_in); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL bit_ready_timeout: got 0 expected 1");
        end
        @(posedge Clk_in); #1;
        Bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [8:0] bits, input int nbits);
        for (int k = nbits - 1; k >= 0; k--) send_bit(bits[k]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge Clk_in); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cur;
        for (int b = 0; b < 4; b++) for (int j = 0; j < 10; j++) books[b][j] = 13'h0;
        books[0][0] = 13'h200; books[0][1] = 13'h402; books[0][2] = 13'h606; books[0][3] = 13'h607;
        books[1][0] = 13'h401; books[1][1] = 13'h400; books[1][2] = 13'h7F4; books[1][3] = 13'h1C00;
        books[1][5] = 13'h80B; books[1][7] = 13'h80A; books[1][9] = 13'h13FF;
        books[2][0] = 13'h200;
        books[3][2] = 13'h606; books[3][5] = 13'h606;

        vecs[0] = '{0, 9'b0,         1, 4'd0};
        vecs[1] = '{0, 9'b10,        2, 4'd1};
        vecs[2] = '{0, 9'b110,       3, 4'd2};
        vecs[3] = '{0, 9'b111,       3, 4'd3};
        vecs[4] = '{1, 9'b01,        2, 4'd0};
        vecs[5] = '{1, 9'b00,        2, 4'd1};
        vecs[6] = '{1, 9'b100,       3, 4'd2};
        vecs[7] = '{1, 9'b1011,      4, 4'd5};
        vecs[8] = '{1, 9'b1010,      4, 4'd7};
        vecs[9] = '{1, 9'b111111111, 9, 4'd9};

        Rst = 1'b1; Start_decode = 1'b0; Bit_in = 1'b0; Bit_valid = 1'b0; Sym_ready = 1'b1;
        for (int j = 0; j < 10; j++) code_in[j] = 13'h0;
        repeat (2) @(posedge Clk_in);
        #1;
        Rst = 1'b0;
        chk("rst_bit_ready", 32'(Bit_ready), 0);
        chk("rst_sym_valid", 32'(Sym_valid), 0);
        chk("rst_sym_out",   32'(Sym_out),   0);
        chk("rst_err",       32'(Err),       0);
        chk("rst_busy",      32'(Busy),      0);

        // Table: book A stream 0,1,0,1,1,0,1,1,1 then book B, back to back.
        cur = -1;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].book != cur) begin
                drain();
                load_book(vecs[i].book);
                cur = vecs[i].book;
            end
            exp_q.push_back(vecs[i].sym);
            send_code(vecs[i].bits, vecs[i].nbits);
        end
        for (int r = 0; r < 20; r++) begin
            int i;
            i = $urandom_range(9, 4);
            exp_q.push_back(vecs[i].sym);
            send_code(vecs[i].bits, vecs[i].nbits);
        end
        drain();
        chk("table_err", 32'(Err), 0);

        // Backpressure: symbol held while the source keeps offering the next bit.
        load_book(0);
        Sym_ready = 1'b0;
        exp_q.push_back(4'd0);
        send_bit(1'b0);
        chk("latency_sym_valid", 32'(Sym_valid), 1);
        Bit_valid = 1'b1;
        Bit_in    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("stall_bit_ready", 32'(Bit_ready), 0);
            chk("stall_sym_valid", 32'(Sym_valid), 1);
            chk("stall_sym_out",   32'(Sym_out),   0);
            @(posedge Clk_in); #1;
        end
        Sym_ready = 1'b1;
        exp_q.push_back(4'd1);
        send_code(9'b10, 2);
        exp_q.push_back(4'd2);
        send_code(9'b110, 3);
        drain();

        // Error: no match within nine bits.
        load_book(2);
        for (int k = 0; k < 8; k++) send_bit(1'b1);
        chk("pre_err", 32'(Err), 0);
        chk("pre_err_busy", 32'(Busy), 1);
        send_bit(1'b1);
        chk("err_set", 32'(Err), 1);
        chk("err_bit_ready", 32'(Bit_ready), 0);
        chk("err_busy", 32'(Busy), 0);
        chk("err_sym_valid", 32'(Sym_valid), 0);
        Bit_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk_in); #1;
            chk("err_sticky", 32'(Err), 1);
            chk("err_hold_ready", 32'(Bit_ready), 0);
        end
        Bit_valid = 1'b0;
        load_book(0);
        chk("err_cleared", 32'(Err), 0);
        chk("err_restart_busy", 32'(Busy), 1);

        // Duplicate entries: lowest index wins.
        load_book(3);
        exp_q.push_back(4'd2);
        send_code(9'b110, 3);
        drain();

        // Reset mid-codeword.
        load_book(0);
        send_code(9'b11, 2);
        Rst = 1'b1;
        @(posedge Clk_in); #1;
        Rst = 1'b0;
        chk("mid_rst_bit_ready", 32'(Bit_ready), 0);
        chk("mid_rst_sym_valid", 32'(Sym_valid), 0);
        chk("mid_rst_sym_out",   32'(Sym_out),   0);
        chk("mid_rst_err",       32'(Err),       0);
        chk("mid_rst_busy",      32'(Busy),      0);
        load_book(0);
        exp_q.push_back(4'd1);
        send_code(9'b10, 2);
        drain();

        // Start_decode while a symbol is pending discards it and empties the accumulator.
        load_book(0);
        Sym_ready = 1'b0;
        send_code(9'b10, 2);
        chk("pend_sym_valid", 32'(Sym_valid), 1);
        load_book(0);
        chk("restart_sym_valid", 32'(Sym_valid), 0);
        chk("restart_bit_ready", 32'(Bit_ready), 1);
        Sym_ready = 1'b1;
        exp_q.push_back(4'd0);
        send_bit(1'b0);
        chk("restart_latency", 32'(Sym_valid), 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
